// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_transmitter
// Brief    : I2S bus master; derives SCK/WS from CLK and serialises stereo
//            frames taken from a one-frame valid/ready holding buffer.
//            Option macro: I2S_TX_REPEAT_ON_UNDERRUN_EN (repeat last frame
//            on underrun instead of sending zeros).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SCK_DIV      = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic                    underrun,
  output logic                    busy,
  output logic                    I2S_SCK,
  output logic                    I2S_WS,
  output logic                    I2S_SD
);

  localparam int KW = $clog2(2 * SLOT_WIDTH);
  localparam int DW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [KW-1:0] c_K_LAST   = KW'(2 * SLOT_WIDTH - 1);
  localparam logic [KW-1:0] c_K_RIGHT  = KW'(SLOT_WIDTH);
  localparam logic [DW-1:0] c_DIV_LAST = DW'(SCK_DIV - 1);

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic                    w_active;
  logic [DW-1:0]           r_div;
  logic [KW-1:0]           r_k;
  logic                    r_sck;
  logic                    r_ws;
  logic                    r_sd;
  logic                    r_underrun;
  logic                    r_buf_full;
  logic [SAMPLE_WIDTH-1:0] r_buf_l;
  logic [SAMPLE_WIDTH-1:0] r_buf_r;
  logic [SAMPLE_WIDTH-1:0] r_tx_l;
  logic [SAMPLE_WIDTH-1:0] r_tx_r;
  logic                    w_tick;
  logic                    w_fall;
  logic                    w_frame_start;
  logic                    w_to_idle;
  logic                    w_sd_next;

  assign w_tick        = w_active && (r_div == c_DIV_LAST);
  assign w_fall        = w_tick && r_sck;
  assign w_frame_start = w_fall && (r_k == '0);
  assign w_to_idle     = w_frame_start && (r_state == c_DRAIN) && !enable;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Re-enable during DRAIN wins over the end-of-frame exit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (enable) w_state_next = c_RUN;
      c_RUN:   if (!enable) w_state_next = c_DRAIN;
      c_DRAIN: begin
        if (enable) begin
          w_state_next = c_RUN;
        end else if (w_frame_start) begin
          w_state_next = c_IDLE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_active = (r_state != c_IDLE);
    busy     = w_active;
  end

  // Bit for the falling edge about to happen at index r_k.
  always_comb begin
    w_sd_next = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (r_k == KW'(SAMPLE_WIDTH - i)) w_sd_next = r_tx_l[i];
      if (((SLOT_WIDTH + SAMPLE_WIDTH - i) < 2 * SLOT_WIDTH) &&
          (r_k == KW'(SLOT_WIDTH + SAMPLE_WIDTH - i))) w_sd_next = r_tx_r[i];
    end
    if ((SAMPLE_WIDTH == SLOT_WIDTH) && (r_k == '0)) w_sd_next = r_tx_r[0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div      <= '0;
      r_k        <= '0;
      r_sck      <= 1'b0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
      r_tx_l     <= '0;
      r_tx_r     <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (frame_valid && !r_buf_full) begin
        r_buf_l    <= left_in;
        r_buf_r    <= right_in;
        r_buf_full <= 1'b1;
      end
      if (!w_active) begin
        r_div <= '0;
        r_k   <= '0;
        r_sck <= 1'b0;
        r_ws  <= 1'b0;
        r_sd  <= 1'b0;
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) r_sck <= ~r_sck;
        if (w_fall) begin
          if (w_to_idle) begin
            r_ws <= 1'b0;
            r_sd <= 1'b0;
            r_k  <= '0;
          end else begin
            r_ws <= (r_k >= c_K_RIGHT);
            r_sd <= w_sd_next;
            r_k  <= (r_k == c_K_LAST) ? '0 : r_k + 1'b1;
            if (r_k == '0) begin
              if (r_buf_full) begin
                r_tx_l     <= r_buf_l;
                r_tx_r     <= r_buf_r;
                r_buf_full <= 1'b0;
              end else begin
                r_underrun <= 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                r_tx_l <= r_tx_l;
                r_tx_r <= r_tx_r;
`else
                r_tx_l <= '0;
                r_tx_r <= '0;
`endif
              end
            end
          end
        end
      end
    end
  end

  assign frame_ready = !r_buf_full;
  assign underrun    = r_underrun;
  assign I2S_SCK     = r_sck;
  assign I2S_WS      = r_ws;
  assign I2S_SD      = r_sd;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_transmitter
// Brief    : Random-traffic bench for i2s_transmitter against a cycle-count
//            based reference model of the I2S bus and holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_transmitter;

  localparam int SW    = 24;
  localparam int SLW   = 32;
  localparam int DIV   = 8;
  localparam int FRAME = 2 * SLW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          enable = 1'b0;
  logic          frame_valid = 1'b0;
  logic [SW-1:0] left_in = '0;
  logic [SW-1:0] right_in = '0;
  logic          frame_ready, underrun, busy, I2S_SCK, I2S_WS, I2S_SD;

  always #5 CLK = ~CLK;

  i2s_transmitter #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLW), .SCK_DIV(DIV)) u_dut (
    .CLK(CLK), .RST(RST), .enable(enable),
    .left_in(left_in), .right_in(right_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .underrun(underrun), .busy(busy),
    .I2S_SCK(I2S_SCK), .I2S_WS(I2S_WS), .I2S_SD(I2S_SD)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 drain; bus timing from CLK count since run start.
  int              m_state = 0;
  int              m_cyc = 0;
  int              m_k = 0;
  bit              m_newfall = 0;
  logic [2*SW-1:0] m_q[$];
  logic [SW-1:0]   m_cur_l = '0;
  logic [SW-1:0]   m_cur_r = '0;
  logic            exp_sck = 0, exp_ws = 0, exp_sd = 0, exp_ur = 0;

  logic            p_rst, p_en, p_valid;
  logic [SW-1:0]   p_l, p_r;

  function automatic logic sd_bit(input int k);
    logic [SW-1:0] t;
    if (k >= 1 && k <= SW) begin
      t = m_cur_l >> (SW - k);
      return t[0];
    end
    if (k >= SLW + 1 && k <= SLW + SW) begin
      t = m_cur_r >> (SLW + SW - k);
      return t[0];
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit can_accept;
    int k;
    m_newfall = 0;
    exp_ur    = 0;
    if (p_rst) begin
      m_state = 0; m_cyc = 0; m_q.delete();
      m_cur_l = '0; m_cur_r = '0;
      exp_sck = 0; exp_ws = 0; exp_sd = 0;
      return;
    end
    can_accept = (m_q.size() == 0);
    if (m_state == 0) begin
      if (p_en) begin
        m_state = 1;
        m_cyc   = 0;
      end
    end else begin
      m_cyc++;
      exp_sck = ((m_cyc / DIV) % 2) == 1;
      if (m_cyc % (2 * DIV) == 0) begin
        k = (m_cyc / (2 * DIV) - 1) % FRAME;
        m_k = k;
        m_newfall = 1;
        if (k == 0 && m_state == 2 && !p_en) begin
          m_state = 0; m_cyc = 0;
          exp_sck = 0; exp_ws = 0; exp_sd = 0;
        end else begin
          exp_ws = (k >= SLW);
          if (k == 0) begin
            exp_sd = (SW == SLW) ? m_cur_r[0] : 1'b0;
            if (m_q.size() > 0) begin
              {m_cur_l, m_cur_r} = m_q.pop_front();
            end else begin
              exp_ur = 1;
`ifndef I2S_TX_REPEAT_ON_UNDERRUN_EN
              m_cur_l = '0;
              m_cur_r = '0;
`endif
            end
          end else begin
            exp_sd = sd_bit(k);
          end
        end
      end
      if (m_state == 1 && !p_en) m_state = 2;
      else if (m_state == 2 && p_en) m_state = 1;
    end
    if (p_valid && can_accept) m_q.push_back({p_l, p_r});
  endtask

  task automatic capture_inputs();
    p_rst = RST; p_en = enable; p_valid = frame_valid; p_l = left_in; p_r = right_in;
  endtask

  initial begin
    @(negedge CLK);
    capture_inputs();
    forever begin
      @(negedge CLK);
      model_step();
      check_value("sck",         I2S_SCK,     exp_sck);
      check_value("ws",          I2S_WS,      exp_ws);
      check_value("sd",          I2S_SD,      exp_sd);
      check_value("underrun",    underrun,    exp_ur);
      check_value("busy",        busy,        m_state != 0);
      check_value("frame_ready", frame_ready, m_q.size() == 0);
      capture_inputs();
    end
  end

  // Producer: never retracts an offered frame; first frame is the fixed pattern.
  bit feed_en    = 0;
  int feed_prob  = 100;
  bit first_data = 1;
  initial begin
    bit hs;
    forever begin
      @(negedge CLK);
      hs = frame_valid && frame_ready;
      @(posedge CLK);
      #2;
      if (!frame_valid || hs) begin
        if (feed_en && ($urandom_range(99, 0) < feed_prob)) begin
          frame_valid = 1'b1;
          if (first_data) begin
            left_in = 24'hA1B2C3; right_in = 24'h123456; first_data = 0;
          end else begin
            left_in = SW'($urandom()); right_in = SW'($urandom());
          end
        end else begin
          frame_valid = 1'b0;
        end
      end
    end
  end

  task automatic wait_k(input int target);
    bit got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge CLK);
      #2;
      if (m_newfall && m_k == target) got = 1;
    end
    check_value("wait_k", got, 1'b1);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) wait_k(0);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge CLK);
      #2;
      if (m_state == 0) got = 1;
    end
    check_value("wait_idle", got, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    feed_en = 1;
    repeat (4) @(posedge CLK);
    #2;
    feed_en = 0;
    repeat (5) @(posedge CLK);
    #2;
    enable = 1'b1;
    wait_frames(2);
    feed_en = 1; feed_prob = 100;
    wait_frames(3);
    feed_prob = 40;
    wait_frames(3);
    feed_en = 0;
    wait_frames(3);
    feed_en = 1; feed_prob = 100;
    wait_k(10);
    enable = 1'b0;
    wait_idle();
    repeat (20) @(posedge CLK);
    #2;
    enable = 1'b1;
    wait_frames(1);
    wait_k(10);
    enable = 1'b0;
    wait_k(40);
    enable = 1'b1;
    wait_frames(2);
    wait_k(20);
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    wait_frames(2);
    feed_en = 0;
    enable  = 1'b0;
    wait_idle();
    repeat (10) @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
